sd_cmd_engine: RTL

CPU-mapped SD-card command sequencer for the SPI path. It sits upstream of the SPI byte engine and drives it through a single-byte request/done handshake. From a command index and a 32-bit argument loaded by the 6502, it builds the 6-byte SD command frame, including a hardware-generated CRC7. It then polls response bytes until it sees an R1 response or its poll limit expires. Chip select is not handled here; the SPI controller's control register keeps that job.

---
 rtl/sd_cmd_engine.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_engine.sv
// SD-card command sequencer for the SPI path: builds the 6-byte command frame
// with a hardware CRC7, then polls response bytes until an R1 arrives or the limit expires.
module sd_cmd_engine (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cs,
    input  logic       i_rwb,
    input  logic [2:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_xfer_req,
    output logic [7:0] o_xfer_tx,
    input  logic       i_xfer_done,
    input  logic [7:0] i_xfer_rx,
    output logic       o_busy,
    output logic       o_irq
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_WAIT_TX = 3'd2,
        S_POLL    = 3'd3,
        S_WAIT_RX = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [7:0]  limit;
    logic [7:0]  r1;
    logic        done_bit;
    logic        timeout_bit;
    logic        busy;
    logic        req;
    logic [7:0]  tx;
    logic [2:0]  idx;
    logic [8:0]  poll_cnt;
    logic [6:0]  crc;
    logic [7:0]  frame_byte;
    logic        wr;
    logic        idle_wr;
    logic        go;
    logic        clr;

    // Serial CRC7 (x^7 + x^3 + 1), one whole byte MSB-first per call.
    function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] b);
        logic [6:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[6] ^ b[i];
            r  = {r[5:0], 1'b0};
            if (fb) begin
                r = r ^ 7'h09;
            end
        end
        return r;
    endfunction

    assign wr      = i_cs & ~i_rwb;
    assign idle_wr = wr && (state == S_IDLE);
    assign go      = idle_wr && (i_addr == 3'd5) && i_data[0];
    assign clr     = idle_wr && (i_addr == 3'd5) && i_data[1];

    always_comb begin
        frame_byte = 8'hFF;
        case (idx)
            3'd0:    frame_byte = {2'b01, cmd};
            3'd1:    frame_byte = arg[31:24];
            3'd2:    frame_byte = arg[23:16];
            3'd3:    frame_byte = arg[15:8];
            3'd4:    frame_byte = arg[7:0];
            3'd5:    frame_byte = {crc, 1'b1};
            default: frame_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_next = S_SEND;
                end
            end
            S_SEND:    state_next = S_WAIT_TX;
            S_WAIT_TX: begin
                if (i_xfer_done) begin
                    state_next = (idx == 3'd5) ? S_POLL : S_SEND;
                end
            end
            S_POLL:    state_next = S_WAIT_RX;
            S_WAIT_RX: begin
                if (i_xfer_done) begin
                    if (!i_xfer_rx[7] || (poll_cnt == 9'd1)) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_POLL;
                    end
                end
            end
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cmd         <= 6'd0;
            arg         <= 32'd0;
            limit       <= 8'd8;
            r1          <= 8'hFF;
            done_bit    <= 1'b0;
            timeout_bit <= 1'b0;
            busy        <= 1'b0;
            req         <= 1'b0;
            tx          <= 8'hFF;
            idx         <= 3'd0;
            poll_cnt    <= 9'd0;
            crc         <= 7'd0;
        end else begin
            req <= (state == S_SEND) || (state == S_POLL);
            // Configuration only changes in IDLE so the frame stays stable in flight.
            if (idle_wr) begin
                case (i_addr)
                    3'd0:    cmd         <= i_data[5:0];
                    3'd1:    arg[31:24]  <= i_data;
                    3'd2:    arg[23:16]  <= i_data;
                    3'd3:    arg[15:8]   <= i_data;
                    3'd4:    arg[7:0]    <= i_data;
                    3'd7:    limit       <= i_data;
                    default: ;
                endcase
            end
            case (state)
                S_IDLE: begin
                    if (go || clr) begin
                        done_bit    <= 1'b0;
                        timeout_bit <= 1'b0;
                    end
                    if (go) begin
                        idx <= 3'd0;
                        crc <= 7'd0;
                    end
                end
                S_SEND: begin
                    busy <= 1'b1;
                    tx   <= frame_byte;
                    if (idx != 3'd5) begin
                        crc <= crc7_byte(crc, frame_byte);
                    end
                end
                S_WAIT_TX: begin
                    if (i_xfer_done) begin
                        if (idx != 3'd5) begin
                            idx <= idx + 3'd1;
                        end else begin
                            poll_cnt <= (limit == 8'd0) ? 9'd256 : {1'b0, limit};
                        end
                    end
                end
                S_POLL: tx <= 8'hFF;
                S_WAIT_RX: begin
                    if (i_xfer_done) begin
                        r1 <= i_xfer_rx;
                        if (i_xfer_rx[7]) begin
                            poll_cnt <= poll_cnt - 9'd1;
                            if (poll_cnt == 9'd1) begin
                                timeout_bit <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_bit <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_data = 8'h00;
        case (i_addr)
            3'd0:    o_data = {2'b00, cmd};
            3'd1:    o_data = arg[31:24];
            3'd2:    o_data = arg[23:16];
            3'd3:    o_data = arg[15:8];
            3'd4:    o_data = arg[7:0];
            3'd5:    o_data = {busy, done_bit, timeout_bit, 5'b00000};
            3'd6:    o_data = r1;
            3'd7:    o_data = limit;
            default: o_data = 8'h00;
        endcase
    end

    assign o_xfer_req = req;
    assign o_xfer_tx  = tx;
    assign o_busy     = busy;
    assign o_irq      = done_bit;

endmodule
